arbiter8_pri: RTL and testbench
===============================

Name: arbiter8_pri

Overview:
- 8-requester priority arbiter that sequences access to one shared resource.
- Resolves concurrent requests with 8-to-3 priority encoding (index 7 highest) and issues a registered one-hot grant plus encoded index.
- Holds each grant until the requester releases it or a hold limit expires, then inserts a turnaround gap.
- Provides an active-low enable input and an enable-out for cascading, matching the team's 8-3 priority encoder convention.

Parameters:
- MAX_HOLD, 16: maximum consecutive granted cycles per grant; 0 = unlimited.
- CNT_W, 5: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  synchronous reset, active-high.
- iReq  input  8  request lines, level-sensitive; bit 7 is highest fixed priority.
- iEI  input  1  active-low enable; 1 blocks new grants.
- oGnt  output  8  registered one-hot grant; all zero when nothing is granted.
- oGntIdx  output  3  registered index of the granted requester.
- oValid  output  1  registered; 1 while any grant is active.
- oEO  output  1  registered; 1 when enabled, idle and no eligible request (cascade to a lower arbiter).
- oTimeout  output  1  registered one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (iRst=1 at an edge):
  - State goes to IDLE.
  - oGnt=0, oGntIdx=0, oValid=0, oEO=0, oTimeout=0.
  - Hold counter=0 and mask=0.
  - Applies from any state, including mid-grant.
- Eligible set: elig = iReq & ~mask.
- States:
  - IDLE: if iEI=0 and elig≠0, encode the highest eligible index k. Next edge: GRANT, oGnt=1<<k, oGntIdx=k, oValid=1, counter=1. Otherwise stay in IDLE.
  - GRANT, release: if iReq[k]=0 at an edge, go to GAP and clear oGnt/oValid. oGntIdx keeps its last value.
  - GRANT, timeout: else if MAX_HOLD≠0 and counter==MAX_HOLD, go to GAP, clear the grant, pulse oTimeout=1 for that one cycle, and set mask[k]=1.
  - GRANT, hold: otherwise stay in GRANT and increment counter.
  - GAP: one cycle with oGnt=0, then unconditionally IDLE.
- Latency:
  - Request to grant: 1 cycle from IDLE.
  - Release to next grant: 2 cycles of oGnt=0 (GAP, then IDLE).
- iEI=1 blocks only new grants. An active grant continues. In GRANT/GAP, iEI is ignored until IDLE.
- oEO = registered (iEI==0 && next state==IDLE && elig==0). It is 0 whenever iEI=1.
- Mask: mask[i] clears on any edge where iReq[i]=0, so a timed-out requester must drop its request before it can win again. Masked requests do not affect oEO.
- Simultaneous release and timeout in the same cycle: release wins, no oTimeout pulse, no mask set.
- Requests arriving during GRANT/GAP are not latched. They are re-evaluated as levels in IDLE.
- oGnt is always one-hot or zero. oValid == |oGnt.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- When defined:
  - A 3-bit priority pointer (reset value 7) sets the highest-priority index.
  - Search order is descending from the pointer with wrap 0→7.
  - On every grant to k, the pointer updates to k-1 mod 8.
- When undefined: fixed priority, index 7 highest, and no pointer register exists.
- Timeout masking applies in both modes.

Test Plan:
- Fixed priority: reset, iEI=0, iReq=8'b1010_0100 → next cycle oGnt=8'h80, oGntIdx=7, oValid=1, oEO=0.
- Handover: from the previous state, drop iReq[7] → oGnt=0 for 2 cycles, then oGnt=8'h20, oGntIdx=5.
- Timeout: MAX_HOLD=4, iReq=8'h08 held → oGnt=8'h08 for 4 cycles, oTimeout=1 for 1 cycle, then no regrant and oEO=1 while iReq[3] stays high. Drop then reassert iReq[3] → granted again.
- Enable: iEI=1 with iReq=8'hFF from IDLE → oGnt=0, oEO=0 indefinitely. With iEI=0 and iReq=0 → oEO=1 after 1 cycle.
- Reset mid-grant: iRst=1 while oGnt=8'h02 → next cycle all outputs 0, mask=0, state IDLE.
- ROUND_ROBIN_EN: iReq=8'hFF, each grant released after 1 cycle → grant index sequence 7,6,5,4,3,2,1,0,7. Without the macro → 7,7,7.

Source files
------------

// File: rtl/arbiter8_pri.sv
// 8-requester priority arbiter: registered one-hot grant, hold limit, one-cycle turnaround gap.
// Define ROUND_ROBIN_EN for a rotating priority pointer; otherwise index 7 always has priority.
module arbiter8_pri #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iReq,
  input  logic       iEI,
  output logic [7:0] oGnt,
  output logic [2:0] oGntIdx,
  output logic       oValid,
  output logic       oEO,
  output logic       oTimeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] cntReg;
  logic [7:0]       maskReg, maskNext, elig;
  logic [2:0]       encIdx;
  logic             encHit, releaseHit, timeoutHit, revoke, eoNext;

  assign elig   = iReq & ~maskReg;
  assign encHit = |elig;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptrReg;
  logic [2:0] cand;

  // Walk from the lowest priority up to the pointer so the last hit is the winner.
  always_comb begin
    encIdx = '0;
    cand   = '0;
    for (int off = 7; off >= 0; off--) begin
      cand = ptrReg - 3'(off);
      if (elig[cand]) encIdx = cand;
    end
  end
`else
  always_comb begin
    encIdx = '0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) encIdx = 3'(i);
    end
  end
`endif

  assign releaseHit = ~iReq[oGntIdx];
  // With MAX_HOLD == 0 the counter may wrap freely; it is never compared.
  assign timeoutHit = (MAX_HOLD != 0) && (cntReg == CNT_W'(MAX_HOLD));
  assign revoke     = (stateReg == GRANT) && !releaseHit && timeoutHit;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (!iEI && encHit) stateNext = GRANT;
      GRANT:   if (releaseHit || timeoutHit) stateNext = GAP;
      GAP:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign eoNext = !iEI && (stateNext == IDLE) && !encHit;

  // A mask bit survives only while its request stays high; a revoke sets it.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign maskNext[gi] = (revoke && (oGntIdx == 3'(gi))) ? 1'b1 : (maskReg[gi] & iReq[gi]);
    end
  endgenerate

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      maskReg  <= '0;
      oGnt     <= '0;
      oGntIdx  <= '0;
      oValid   <= 1'b0;
      oEO      <= 1'b0;
      oTimeout <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptrReg   <= 3'd7;
`endif
    end else begin
      stateReg <= stateNext;
      maskReg  <= maskNext;
      oEO      <= eoNext;
      oTimeout <= revoke;
      case (stateReg)
        IDLE: begin
          if (stateNext == GRANT) begin
            oGnt    <= 8'b1 << encIdx;
            oGntIdx <= encIdx;
            oValid  <= 1'b1;
            cntReg  <= CNT_W'(1);
`ifdef ROUND_ROBIN_EN
            ptrReg  <= encIdx - 3'd1;
`endif
          end
        end
        GRANT: begin
          if (stateNext == GAP) begin
            oGnt   <= '0;
            oValid <= 1'b0;
          end else begin
            cntReg <= cntReg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter8_pri.sv
// Scoreboard bench for arbiter8_pri (MAX_HOLD=4): expected outputs are queued per cycle,
// then popped and compared one cycle after the stimulus is applied.
module tb_arbiter8_pri;

  logic       iClk = 1'b0;
  logic       iRst, iEI;
  logic [7:0] iReq;
  logic [7:0] oGnt;
  logic [2:0] oGntIdx;
  logic       oValid, oEO, oTimeout;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       eo;
    logic       tout;
  } obs_t;

  obs_t       expQ[$];
  logic [9:0] stimQ[$];   // {rst, ei, req}
  int         nChecks = 0;
  int         nFails  = 0;

  always #5 iClk = ~iClk;

  arbiter8_pri #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iEI(iEI),
    .oGnt(oGnt), .oGntIdx(oGntIdx), .oValid(oValid), .oEO(oEO), .oTimeout(oTimeout)
  );

  function automatic obs_t mk(logic [7:0] g, logic [2:0] k, logic eo, logic tout);
    mk = '{gnt: g, idx: k, valid: |g, eo: eo, tout: tout};
  endfunction

  function automatic obs_t observed();
    observed = '{gnt: oGnt, idx: oGntIdx, valid: oValid, eo: oEO, tout: oTimeout};
  endfunction

  task automatic step(logic rst, logic ei, logic [7:0] req, obs_t e);
    stimQ.push_back({rst, ei, req});
    expQ.push_back(e);
  endtask

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    step(1, 0, 8'hFF, mk(8'h00, 0, 0, 0));
    step(1, 1, 8'h00, mk(8'h00, 0, 0, 0));
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL reset[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok reset[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  task automatic test_fixed_priority();
    obs_t got, e;
    step(0, 0, 8'hA4, mk(8'h80, 7, 0, 0));
    step(0, 0, 8'hA4, mk(8'h80, 7, 0, 0));
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL fixed_pri[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok fixed_pri[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  task automatic test_handover();
    obs_t got, e;
    step(0, 0, 8'h24, mk(8'h00, 7, 0, 0));
    step(0, 0, 8'h24, mk(8'h00, 7, 0, 0));
    step(0, 0, 8'h24, mk(8'h20, 5, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 5, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 5, 1, 0));
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL handover[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok handover[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  task automatic test_timeout();
    obs_t got, e;
    for (int n = 0; n < 4; n++) step(0, 0, 8'h08, mk(8'h08, 3, 0, 0));
    step(0, 0, 8'h08, mk(8'h00, 3, 0, 1));
    for (int n = 0; n < 3; n++) step(0, 0, 8'h08, mk(8'h00, 3, 1, 0));
    step(0, 0, 8'h00, mk(8'h00, 3, 1, 0));
    step(0, 0, 8'h08, mk(8'h08, 3, 0, 0));
    // Release on the very edge the limit is reached: no pulse, no mask.
    for (int n = 0; n < 3; n++) step(0, 0, 8'h08, mk(8'h08, 3, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 3, 0, 0));
    step(0, 0, 8'h08, mk(8'h00, 3, 0, 0));
    step(0, 0, 8'h08, mk(8'h08, 3, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 3, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 3, 1, 0));
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL timeout[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok timeout[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  task automatic test_enable();
    obs_t got, e;
    for (int n = 0; n < 4; n++) step(0, 1, 8'hFF, mk(8'h00, 3, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 3, 1, 0));
    step(0, 0, 8'h02, mk(8'h02, 1, 0, 0));
    step(0, 1, 8'h02, mk(8'h02, 1, 0, 0));
    step(0, 1, 8'h00, mk(8'h00, 1, 0, 0));
    step(0, 1, 8'h00, mk(8'h00, 1, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 1, 1, 0));
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL enable[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok enable[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  task automatic test_reset_mid_grant();
    obs_t got, e;
    for (int n = 0; n < 4; n++) step(0, 0, 8'h02, mk(8'h02, 1, 0, 0));
    step(0, 0, 8'h02, mk(8'h00, 1, 0, 1));
    step(0, 0, 8'h02, mk(8'h00, 1, 1, 0));
    step(1, 0, 8'h02, mk(8'h00, 0, 0, 0));
    step(0, 0, 8'h02, mk(8'h02, 1, 0, 0));
    step(1, 0, 8'h02, mk(8'h00, 0, 0, 0));
    step(0, 0, 8'h00, mk(8'h00, 0, 1, 0));
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL reset_mid[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok reset_mid[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    logic [2:0] k;
    for (int n = 0; n < 9; n++) begin
`ifdef ROUND_ROBIN_EN
      k = 3'(7 - n);
`else
      k = 3'd7;
`endif
      step(0, 0, 8'hFF, mk(8'h01 << k, k, 0, 0));
      step(0, 0, 8'hFF & ~(8'h01 << k), mk(8'h00, k, 0, 0));
      step(0, 0, 8'hFF, mk(8'h00, k, 0, 0));
    end
    foreach (stimQ[i]) begin
      {iRst, iEI, iReq} = stimQ[i];
      cyc();
      e = expQ.pop_front(); got = observed(); nChecks++;
      if (got !== e) begin nFails++; $display("FAIL back_to_back[%0d] got=%h expected=%h", i, got, e); end
      else $display("ok back_to_back[%0d] %h", i, got);
    end
    stimQ.delete();
  endtask

  initial begin
    iRst = 1'b1;
    iEI  = 1'b0;
    iReq = 8'h00;
    test_reset();
    test_fixed_priority();
    test_handover();
    test_timeout();
    test_enable();
    test_reset_mid_grant();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
